// File: rtl/cart_psram_reader.sv
// Serves Atari 7800 cart bus reads from a game image held in PSRAM, one byte read per new address.
// Optional macro CART_PREFETCH_EN adds a one-entry sequential prefetch buffer (offset+1).
module cart_psram_reader #(
  parameter logic [15:0] ROM_BASE       = 16'h4000,
  parameter logic [21:0] PSRAM_OFFSET   = 22'h000000,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [7:0]  FILL_BYTE      = 8'hEA
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [15:0] bus_addr,
  input  logic        bus_rw,
  input  logic [31:0] rom_size,
  output logic [7:0]  data_out,
  output logic        data_ready,
  output logic        psram_read_req,
  output logic [21:0] psram_addr,
  input  logic [7:0]  psram_read_data,
  input  logic        psram_data_valid,
  input  logic        psram_busy,
  output logic        timeout_err
);
  // state    | meaning
  // IDLE     | waiting for a new (or deferred) bus read
  // ISSUE    | demand read pending, waiting for controller not busy
  // WAIT     | demand read in flight, timeout counter running
  // PF_ISSUE | prefetch of offset+1 pending (CART_PREFETCH_EN only)
  // PF_WAIT  | prefetch in flight (CART_PREFETCH_EN only)
`ifdef CART_PREFETCH_EN
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, PF_ISSUE, PF_WAIT} state_t;
`else
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
`endif

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_LOAD = TW'(TIMEOUT_CYCLES - 1);

  state_t        state, state_d;
  logic          enable_q, pending;
  logic [15:0]   last_addr, offset;
  logic [TW-1:0] tcnt;
  logic          in_win, new_req, addr_ok;
  logic          svc, fill_now, deliver, tmo, tmo_ret, load_cnt, load_addr;
  logic [21:0]   addr_d;
`ifdef CART_PREFETCH_EN
  logic [15:0]   next_off, pf_addr;
  logic [7:0]    pf_data;
  logic          pf_valid, pf_ok, pf_hit, pf_start, pf_fill;

  assign next_off = offset + 16'd1;
  assign pf_ok    = (offset != 16'hFFFF) && ({16'b0, next_off} < rom_size);
`endif

  assign offset  = bus_addr - ROM_BASE;
  assign in_win  = (bus_addr >= ROM_BASE) && ({16'b0, offset} < rom_size);
  assign new_req = enable && bus_rw && ((bus_addr != last_addr) || !enable_q);
  // Without a new request this cycle, bus_addr equals last_addr, so the fetched byte is still wanted.
  assign addr_ok = enable && bus_rw && !pending && !new_req;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d        = state;
    psram_read_req = 1'b0;
    svc            = 1'b0;
    fill_now       = 1'b0;
    deliver        = 1'b0;
    tmo            = 1'b0;
    tmo_ret        = 1'b0;
    load_cnt       = 1'b0;
    load_addr      = 1'b0;
    addr_d         = psram_addr;
`ifdef CART_PREFETCH_EN
    pf_hit         = 1'b0;
    pf_start       = 1'b0;
    pf_fill        = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (enable && bus_rw && (new_req || pending)) begin
          svc = 1'b1;
          if (!in_win) fill_now = 1'b1;
`ifdef CART_PREFETCH_EN
          else if (pf_valid && (bus_addr == pf_addr)) begin
            pf_hit = 1'b1;
            if (pf_ok) begin
              pf_start = 1'b1;
              state_d  = PF_ISSUE;
            end
          end
`endif
          else begin
            load_addr = 1'b1;
            addr_d    = PSRAM_OFFSET + {6'b0, offset};
            state_d   = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (!enable) state_d = IDLE;
        else if (!psram_busy) begin
          psram_read_req = 1'b1;
          load_cnt       = 1'b1;
          state_d        = WAIT;
        end
      end
      WAIT: begin
        if (psram_data_valid) begin
          deliver = addr_ok;
          state_d = IDLE;
`ifdef CART_PREFETCH_EN
          if (addr_ok && pf_ok) begin
            pf_start = 1'b1;
            state_d  = PF_ISSUE;
          end
`endif
        end else if (tcnt == '0) begin
          tmo     = 1'b1;
          tmo_ret = addr_ok;
          state_d = IDLE;
        end
      end
`ifdef CART_PREFETCH_EN
      PF_ISSUE: begin
        if (!enable) state_d = IDLE;
        else if (!psram_busy) begin
          psram_read_req = 1'b1;
          load_cnt       = 1'b1;
          state_d        = PF_WAIT;
        end
      end
      PF_WAIT: begin
        if (psram_data_valid) begin
          pf_fill = 1'b1;
          state_d = IDLE;
        end else if (tcnt == '0) begin
          tmo     = 1'b1;
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
`ifdef CART_PREFETCH_EN
    if (pf_start) begin
      load_addr = 1'b1;
      addr_d    = PSRAM_OFFSET + {6'b0, next_off};
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable_q    <= 1'b0;
      last_addr   <= 16'h0;
      pending     <= 1'b0;
      tcnt        <= '0;
      psram_addr  <= 22'h0;
      data_out    <= FILL_BYTE;
      data_ready  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      enable_q <= enable;
      if (new_req) last_addr <= bus_addr;
      // A request seen while a read is in flight is serviced once IDLE is reached.
      if (!enable)                        pending <= 1'b0;
      else if (new_req && state != IDLE)  pending <= 1'b1;
      else if (svc)                       pending <= 1'b0;
      if (load_cnt)           tcnt <= T_LOAD;
      else if (tcnt != '0)    tcnt <= tcnt - 1'b1;
      if (load_addr) psram_addr <= addr_d;
      if (tmo) timeout_err <= 1'b1;
      if (fill_now || tmo_ret) begin
        data_out   <= FILL_BYTE;
        data_ready <= 1'b1;
      end else if (deliver) begin
        data_out   <= psram_read_data;
        data_ready <= 1'b1;
      end
`ifdef CART_PREFETCH_EN
      else if (pf_hit) begin
        data_out   <= pf_data;
        data_ready <= 1'b1;
      end
`endif
      else if (!enable || !bus_rw || new_req) data_ready <= 1'b0;
    end
  end

`ifdef CART_PREFETCH_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pf_valid <= 1'b0;
      pf_addr  <= 16'h0;
      pf_data  <= 8'h0;
    end else if (pf_start) begin
      pf_valid <= 1'b0;
      pf_addr  <= bus_addr + 16'd1;
    end else if (pf_fill) begin
      pf_valid <= 1'b1;
      pf_data  <= psram_read_data;
    end
  end
`endif

endmodule

// File: tb/tb_cart_psram_reader.sv
// Directed bench for cart_psram_reader: table of single reads plus busy/timeout, abort, reset and prefetch sequences.
module tb_cart_psram_reader;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] bus_addr = 16'h0;
  logic        bus_rw = 1'b1;
  logic [31:0] rom_size = 32'h8000;
  logic [7:0]  psram_read_data = 8'h0;
  logic        psram_data_valid = 1'b0;
  logic        psram_busy = 1'b0;
  logic [7:0]  data_out;
  logic        data_ready, psram_read_req, timeout_err;
  logic [21:0] psram_addr;

  int total = 0;
  int bad = 0;

  cart_psram_reader dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .bus_addr(bus_addr), .bus_rw(bus_rw),
    .rom_size(rom_size), .data_out(data_out), .data_ready(data_ready),
    .psram_read_req(psram_read_req), .psram_addr(psram_addr), .psram_read_data(psram_read_data),
    .psram_data_valid(psram_data_valid), .psram_busy(psram_busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] addr;
    logic        rw;
    logic [31:0] rsize;
    logic        exp_req;
    logic [21:0] exp_pa;
    logic        exp_rdy;
    logic        chk_data;
    logic [7:0]  exp_do;
  } vec_t;

  vec_t vecs [12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Looks for a request now, then after each of up to max clock edges.
  task automatic wait_req(input int max, output bit seen, output logic [21:0] pa, output int n);
    seen = 1'b0;
    pa = '0;
    n = -1;
    for (int i = 0; i <= max; i++) begin
      if (psram_read_req) begin
        seen = 1'b1;
        pa = psram_addr;
        n = i;
        break;
      end
      if (i < max) tick();
    end
  endtask

  // Called in the request cycle; returns a valid pulse one cycle later.
  task automatic serve(input logic [7:0] d);
    tick();
    psram_data_valid = 1'b1;
    psram_read_data = d;
    tick();
    psram_data_valid = 1'b0;
  endtask

  task automatic drain(input int cycles);
    logic [21:0] pa;
    for (int i = 0; i < cycles; i++) begin
      if (psram_read_req) begin
        pa = psram_addr;
        serve(pa[7:0] ^ 8'h4A);
      end else tick();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: summary not reached within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    logic [21:0] pa;
    int n;
    bit any;

    vecs[0]  = '{16'h4010, 1'b1, 32'h0000_8000, 1'b1, 22'h000010, 1'b1, 1'b1, 8'h5A};
    vecs[1]  = '{16'hC100, 1'b1, 32'h0000_8000, 1'b0, 22'h000000, 1'b1, 1'b1, 8'hEA};
    vecs[2]  = '{16'h4000, 1'b1, 32'h0000_8000, 1'b1, 22'h000000, 1'b1, 1'b1, 8'h4A};
    vecs[3]  = '{16'h3FFF, 1'b1, 32'h0000_8000, 1'b0, 22'h000000, 1'b1, 1'b1, 8'hEA};
    vecs[4]  = '{16'h7FFF, 1'b1, 32'h0000_8000, 1'b1, 22'h003FFF, 1'b1, 1'b1, 8'hB5};
    vecs[5]  = '{16'hC000, 1'b1, 32'h0000_8000, 1'b0, 22'h000000, 1'b1, 1'b1, 8'hEA};
    vecs[6]  = '{16'hC001, 1'b1, 32'h0000_8002, 1'b1, 22'h008001, 1'b1, 1'b1, 8'h4B};
    vecs[7]  = '{16'h4100, 1'b1, 32'h0000_0100, 1'b0, 22'h000000, 1'b1, 1'b1, 8'hEA};
    vecs[8]  = '{16'h40FF, 1'b1, 32'h0000_0100, 1'b1, 22'h0000FF, 1'b1, 1'b1, 8'hB5};
    vecs[9]  = '{16'h4234, 1'b0, 32'h0000_8000, 1'b0, 22'h000000, 1'b0, 1'b0, 8'h00};
    vecs[10] = '{16'hFFFF, 1'b1, 32'h0001_0000, 1'b1, 22'h00BFFF, 1'b1, 1'b1, 8'hB5};
    vecs[11] = '{16'h4010, 1'b1, 32'h0000_8000, 1'b1, 22'h000010, 1'b1, 1'b1, 8'h5A};

    tick();
    tick();
    chk("reset data_out", data_out, 8'hEA);
    chk("reset data_ready", data_ready, 0);
    chk("reset req", psram_read_req, 0);
    chk("reset psram_addr", psram_addr, 22'h0);
    chk("reset timeout_err", timeout_err, 0);
    reset_n = 1'b1;
    tick();

    enable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bus_addr = vecs[i].addr;
      bus_rw   = vecs[i].rw;
      rom_size = vecs[i].rsize;
      wait_req(6, seen, pa, n);
      chk($sformatf("v%0d req", i), seen, vecs[i].exp_req);
      if (seen) begin
        chk($sformatf("v%0d psram_addr", i), pa, vecs[i].exp_pa);
        if (i == 0) chk("v0 req latency", n, 1);
        serve(pa[7:0] ^ 8'h4A);
      end
      chk($sformatf("v%0d data_ready", i), data_ready, vecs[i].exp_rdy);
      if (vecs[i].chk_data) chk($sformatf("v%0d data_out", i), data_out, vecs[i].exp_do);
      drain(4);
    end
    bus_rw = 1'b1;
    rom_size = 32'h8000;

    // busy hold, then timeout with no valid
    psram_busy = 1'b1;
    bus_addr = 16'h4050;
    any = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (psram_read_req) any = 1'b1;
    end
    chk("busy no req", any, 0);
    psram_busy = 1'b0;
    #1;
    chk("req after busy fall", psram_read_req, 1);
    chk("busy psram_addr", psram_addr, 22'h000050);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      n++;
      if (data_ready) break;
    end
    chk("timeout cycles", n, 65);
    chk("timeout data_out", data_out, 8'hEA);
    chk("timeout_err set", timeout_err, 1);
    bus_addr = 16'h4010;
    wait_req(6, seen, pa, n);
    chk("post-timeout req", seen, 1);
    if (seen) serve(pa[7:0] ^ 8'h4A);
    chk("post-timeout data_out", data_out, 8'h5A);
    chk("timeout_err sticky", timeout_err, 1);
    drain(4);

    // address change while the read is in flight
    bus_addr = 16'h4000;
    wait_req(6, seen, pa, n);
    chk("abort first req", seen, 1);
    chk("abort first addr", pa, 22'h000000);
    tick();
    bus_addr = 16'h4001;
    tick();
    chk("abort ready cleared", data_ready, 0);
    tick();
    psram_data_valid = 1'b1;
    psram_read_data = 8'h11;
    tick();
    psram_data_valid = 1'b0;
    chk("abort stale discarded", data_ready, 0);
    wait_req(6, seen, pa, n);
    chk("abort second req", seen, 1);
    chk("abort second addr", pa, 22'h000001);
    if (seen) serve(pa[7:0] ^ 8'h4A);
    chk("abort second ready", data_ready, 1);
    chk("abort second data", data_out, 8'h4B);
    drain(4);

    // asynchronous reset in WAIT
    bus_addr = 16'h4030;
    wait_req(6, seen, pa, n);
    chk("rst req", seen, 1);
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst data_out", data_out, 8'hEA);
    chk("rst data_ready", data_ready, 0);
    chk("rst req low", psram_read_req, 0);
    chk("rst psram_addr", psram_addr, 22'h0);
    chk("rst timeout_err", timeout_err, 0);
    enable = 1'b0;
    tick();
    reset_n = 1'b1;
    psram_data_valid = 1'b1;
    psram_read_data = 8'h77;
    any = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      psram_data_valid = 1'b0;
      if (psram_read_req) any = 1'b1;
    end
    chk("late valid ready", data_ready, 0);
    chk("late valid data", data_out, 8'hEA);
    chk("disabled no req", any, 0);
    enable = 1'b1;
    wait_req(6, seen, pa, n);
    chk("re-enable req", seen, 1);
    chk("re-enable addr", pa, 22'h000030);
    if (seen) serve(pa[7:0] ^ 8'h4A);
    chk("re-enable data", data_out, 8'h7A);
    chk("re-enable ready", data_ready, 1);
    drain(4);

    // sequential read 4020 then 4021
    bus_addr = 16'h4020;
    wait_req(6, seen, pa, n);
    chk("seq first addr", pa, 22'h000020);
    if (seen) serve(pa[7:0] ^ 8'h4A);
    chk("seq first data", data_out, 8'h6A);
`ifdef CART_PREFETCH_EN
    wait_req(4, seen, pa, n);
    chk("prefetch req", seen, 1);
    chk("prefetch addr", pa, 22'h000021);
    if (seen) serve(pa[7:0] ^ 8'h4A);
    bus_addr = 16'h4021;
    tick();
    chk("pf hit ready", data_ready, 1);
    chk("pf hit data", data_out, 8'h6B);
    chk("pf hit next addr", psram_addr, 22'h000022);
    drain(4);
`else
    wait_req(4, seen, pa, n);
    chk("no auto req", seen, 0);
    bus_addr = 16'h4021;
    wait_req(6, seen, pa, n);
    chk("demand req", seen, 1);
    chk("demand addr", pa, 22'h000021);
    if (seen) serve(pa[7:0] ^ 8'h4A);
    chk("demand data", data_out, 8'h6B);
    chk("demand ready", data_ready, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
